// File: rtl/dm_bridge_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package  : dm_bridge_pkg                                                   |
// | Purpose  : Shared types and helpers for the data-memory bridge: load FSM   |
// |            state encoding, byte-lane count and a full-word strobe test.    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package dm_bridge_pkg;

  // Byte lanes of the 32-bit data path.
  localparam int LANES = 4;

  // Load sequencing states; stores never leave IDLE.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LD_REQ  = 2'd1,
    ST_LD_WAIT = 2'd2,
    ST_LD_DONE = 2'd3
  } state_t;

  // True when a strobe covers the whole word (required for load forwarding).
  function automatic logic lanes_full(input logic [LANES-1:0] strb);
    return &strb;
  endfunction

endpackage : dm_bridge_pkg
`default_nettype wire

// File: rtl/dm_bridge_store_buf.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : store_buf                                                       |
// | Purpose  : One-entry posted store buffer with a full-word hit query.       |
// | Revision : 1.0 - initial release                                           |
// | Ports    : clk, reset       clock / synchronous active-high reset          |
// |            push, push_*     capture a word-aligned store                   |
// |            pop              drain handshake (bus req && gnt, write)        |
// |            query_addr       word-aligned load address to test for a hit    |
// |            valid/addr/strb/data  buffered entry                            |
// |            hit_full         entry valid, same word, all lanes written      |
// +----------------------------------------------------------------------------+
module store_buf
  import dm_bridge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [LANES-1:0]  push_strb,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  input  logic [ADDR_W-1:0] query_addr,
  output logic              valid,
  output logic [ADDR_W-1:0] addr,
  output logic [LANES-1:0]  strb,
  output logic [DATA_W-1:0] data,
  output logic              hit_full
);

  // A push in the same cycle as a pop refills the entry: the old store is
  // leaving on the bus while the new one takes its place.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      addr  <= '0;
      strb  <= '0;
      data  <= '0;
    end else if (push) begin
      valid <= 1'b1;
      addr  <= push_addr;
      strb  <= push_strb;
      data  <= push_data;
    end else if (pop) begin
      valid <= 1'b0;
    end
  end

  assign hit_full = valid && (addr == query_addr) && lanes_full(strb);

endmodule : store_buf
`default_nettype wire

// File: rtl/dm_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dm_bridge                                                       |
// | Purpose  : Bridges the core's single-cycle MEM-stage DM port onto a        |
// |            req/gnt + rvalid bus. Stores are posted through a one-entry     |
// |            buffer; full-word loads that hit it are forwarded; other loads  |
// |            wait for the buffer to drain and then run a bus read.           |
// | Revision : 1.0 - initial release                                           |
// | Ports    : clk, reset                clock / synchronous active-high reset |
// |            cpu_rd/wr/wea/addr/wdata  MEM-stage request                     |
// |            cpu_rdata, cpu_stall      load word / pipeline freeze (comb)    |
// |            bus_req/we/addr/wstrb/wdata  registered bus request             |
// |            bus_gnt, bus_rvalid, bus_rdata  bus responses                   |
// | Note     : bus_gnt reaches cpu_stall combinationally (a store waiting on   |
// |            the drain is released in the cycle the drain is granted).       |
// +----------------------------------------------------------------------------+
module dm_bridge
  import dm_bridge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int FWD_EN = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [LANES-1:0]  cpu_wea,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [LANES-1:0]  bus_wstrb,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_gnt,
  input  logic              bus_rvalid,
  input  logic [DATA_W-1:0] bus_rdata
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(3));

  state_t            state, state_next;
  logic [ADDR_W-1:0] ld_addr, ld_addr_next;
  logic [DATA_W-1:0] ld_data;

  logic              sb_push, sb_pop, sb_valid, sb_hit, sb_valid_next;
  logic [ADDR_W-1:0] sb_addr;
  logic [LANES-1:0]  sb_strb;
  logic [DATA_W-1:0] sb_data;

  logic              stall_raw, fwd_sel, drain;
  logic [ADDR_W-1:0] cpu_word_addr;

  logic              req_next, we_next;
  logic [ADDR_W-1:0] addr_next;
  logic [LANES-1:0]  strb_next;
  logic [DATA_W-1:0] wdata_next;

  assign cpu_word_addr = cpu_addr & ALIGN_MASK;

  // Only the buffered store is ever presented as a write, so a granted write
  // is exactly the buffer draining.
  assign drain  = bus_req && bus_we && bus_gnt;
  assign sb_pop = drain;

  store_buf #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_store_buf (
    .clk        (clk),
    .reset      (reset),
    .push       (sb_push),
    .push_addr  (cpu_word_addr),
    .push_strb  (cpu_wea),
    .push_data  (cpu_wdata),
    .pop        (sb_pop),
    .query_addr (cpu_word_addr),
    .valid      (sb_valid),
    .addr       (sb_addr),
    .strb       (sb_strb),
    .data       (sb_data),
    .hit_full   (sb_hit)
  );

  // Next state, store capture and stall.
  always_comb begin
    state_next   = state;
    ld_addr_next = ld_addr;
    sb_push      = 1'b0;
    stall_raw    = 1'b0;
    fwd_sel      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cpu_wr) begin
          // A store with no lanes enabled is a no-op.
          if (cpu_wea != '0) begin
            if (!sb_valid || drain) sb_push = 1'b1;
            else                    stall_raw = 1'b1;
          end
        end else if (cpu_rd) begin
          if ((FWD_EN != 0) && sb_hit) begin
            fwd_sel = 1'b1;
          end else begin
            stall_raw = 1'b1;
            // Reads never overtake a buffered store.
            if (!sb_valid || drain) begin
              ld_addr_next = cpu_word_addr;
              state_next   = ST_LD_REQ;
            end
          end
        end
      end
      ST_LD_REQ: begin
        stall_raw = 1'b1;
        if (bus_req && bus_gnt) state_next = ST_LD_WAIT;
      end
      ST_LD_WAIT: begin
        stall_raw = 1'b1;
        if (bus_rvalid) state_next = ST_LD_DONE;
      end
      ST_LD_DONE: begin
        // The core takes the load this cycle; its request is not re-issued.
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Bus outputs are computed from next-cycle state so they can be registered.
  always_comb begin
    sb_valid_next = sb_push || (sb_valid && !sb_pop);
    req_next      = 1'b0;
    we_next       = 1'b0;
    addr_next     = ld_addr_next;
    strb_next     = '0;
    wdata_next    = '0;
    case (state_next)
      ST_IDLE: begin
        req_next   = sb_valid_next;
        we_next    = 1'b1;
        addr_next  = sb_push ? cpu_word_addr : sb_addr;
        strb_next  = sb_push ? cpu_wea       : sb_strb;
        wdata_next = sb_push ? cpu_wdata     : sb_data;
      end
      ST_LD_REQ: req_next = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      ld_addr   <= '0;
      ld_data   <= '0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wstrb <= '0;
      bus_wdata <= '0;
    end else begin
      state     <= state_next;
      ld_addr   <= ld_addr_next;
      bus_req   <= req_next;
      bus_we    <= we_next;
      bus_addr  <= addr_next;
      bus_wstrb <= strb_next;
      bus_wdata <= wdata_next;
      // rvalid outside LD_WAIT belongs to no request of ours.
      if ((state == ST_LD_WAIT) && bus_rvalid) ld_data <= bus_rdata;
    end
  end

  assign cpu_rdata = fwd_sel ? sb_data : ld_data;
  assign cpu_stall = !reset && stall_raw;

endmodule : dm_bridge
`default_nettype wire
